// File: rtl/axi_slv_pkg.sv
// rtl/axi_slv_pkg.sv - response codes, FSM encodings and byte-lane helper for axi4_full_slave_mem
package axi_slv_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/axi_slv_bram.sv
// rtl/axi_slv_bram.sv - simple dual-port RAM, per-byte write enable, synchronous read-first
module axi_slv_bram #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Same-cycle read of a word being written returns the old contents.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W/8; b++) begin
            if (wr_be[b]) begin
                mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi4_full_slave_mem.sv
// rtl/axi4_full_slave_mem.sv - AXI4 INCR-burst slave over on-chip RAM; AXI_SLV_RD_REG_EN adds a read output register
module axi4_full_slave_mem
    import axi_slv_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 128,
    parameter int ID_W      = 12,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     S_AXI_AWID,
    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic [7:0]          S_AXI_AWLEN,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [DATA_W-1:0]   S_AXI_WDATA,
    input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic                S_AXI_WLAST,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [ID_W-1:0]     S_AXI_BID,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [ID_W-1:0]     S_AXI_ARID,
    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic [7:0]          S_AXI_ARLEN,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [ID_W-1:0]     S_AXI_RID,
    output logic [DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RLAST,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);

    localparam int LANES     = byte_lanes(DATA_W);
    localparam int LANE_BITS = $clog2(LANES);
    localparam int MEM_AW    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(LANES);

    function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
        return (a >> LANE_BITS) >= ADDR_W'(MEM_DEPTH);
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return a[LANE_BITS +: MEM_AW];
    endfunction

    logic [DATA_W/8-1:0] ram_wr_be;
    logic [DATA_W-1:0]   ram_rd_data;

    // ---------------- write direction ----------------
    w_state_t          w_state, w_state_nx;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic              w_err;
    logic              aw_hs, w_hs, w_final;

    assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
    assign w_final = (w_cnt == w_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_nx;
        end
    end

    // The burst ends on the slave's own beat count; a misplaced WLAST only flags an error.
    always_comb begin
        w_state_nx    = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                S_AXI_AWREADY = 1'b1;
                if (S_AXI_AWVALID) w_state_nx = W_DATA;
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && w_final) w_state_nx = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_id   <= '0;
            w_addr <= '0;
            w_len  <= '0;
            w_cnt  <= '0;
            w_err  <= 1'b0;
        end else if (aw_hs) begin
            w_id   <= S_AXI_AWID;
            w_addr <= S_AXI_AWADDR;
            w_len  <= S_AXI_AWLEN;
            w_cnt  <= '0;
            w_err  <= 1'b0;
        end else if (w_hs) begin
            w_addr <= w_addr + ADDR_STEP;
            w_cnt  <= w_cnt + 8'd1;
            if (out_of_range(w_addr) || (S_AXI_WLAST != w_final)) begin
                w_err <= 1'b1;
            end
        end
    end

    assign ram_wr_be   = (w_hs && !out_of_range(w_addr)) ? S_AXI_WSTRB : '0;
    assign S_AXI_BID   = w_id;
    assign S_AXI_BRESP = ((w_state == W_RESP) && w_err) ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read direction ----------------
    r_state_t          r_state, r_state_nx;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len, r_cnt;
    logic              r_oor;
    logic              ar_hs, r_hs, r_final, rd_issue;
    logic [ADDR_W-1:0] rd_addr;
    logic              beat_valid, beat_oor;
    logic [DATA_W-1:0] beat_data;

    assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs     = S_AXI_RVALID && S_AXI_RREADY;
    assign r_final  = (r_cnt == r_len);
    assign rd_issue = ar_hs || (r_hs && !r_final);
    assign rd_addr  = (r_state == R_IDLE) ? S_AXI_ARADDR : r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_nx;
        end
    end

    always_comb begin
        r_state_nx    = r_state;
        S_AXI_ARREADY = 1'b0;
        case (r_state)
            R_IDLE: begin
                S_AXI_ARREADY = 1'b1;
                if (S_AXI_ARVALID) r_state_nx = R_DATA;
            end
            R_DATA: begin
                if (r_hs && r_final) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    // r_addr always points at the next word to fetch; r_oor tags the word just fetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id   <= '0;
            r_addr <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_oor  <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_id  <= S_AXI_ARID;
                r_len <= S_AXI_ARLEN;
                r_cnt <= '0;
            end else if (r_hs) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (rd_issue) begin
                r_addr <= rd_addr + ADDR_STEP;
                r_oor  <= out_of_range(rd_addr);
            end
        end
    end

`ifdef AXI_SLV_RD_REG_EN
    logic              rd_pend, rd_vld_q, rd_oor_q;
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend   <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_oor_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_pend <= rd_issue;
            if (rd_pend) begin
                rd_vld_q  <= 1'b1;
                rd_data_q <= ram_rd_data;
                rd_oor_q  <= r_oor;
            end else if (r_hs) begin
                rd_vld_q <= 1'b0;
            end
        end
    end

    assign beat_valid = rd_vld_q;
    assign beat_data  = rd_data_q;
    assign beat_oor   = rd_oor_q;
`else
    // RAM output register only reloads on a fetch, so it holds steady through RREADY stalls.
    assign beat_valid = (r_state == R_DATA);
    assign beat_data  = ram_rd_data;
    assign beat_oor   = r_oor;
`endif

    assign S_AXI_RVALID = beat_valid;
    assign S_AXI_RID    = r_id;
    assign S_AXI_RLAST  = beat_valid && r_final;
    assign S_AXI_RRESP  = (beat_valid && beat_oor) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RDATA  = (beat_valid && !beat_oor) ? beat_data : '0;

    axi_slv_bram #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH),
        .AW     (MEM_AW)
    ) u_bram (
        .clk     (clk),
        .wr_be   (ram_wr_be),
        .wr_addr (word_idx(w_addr)),
        .wr_data (S_AXI_WDATA),
        .rd_en   (rd_issue),
        .rd_addr (word_idx(rd_addr)),
        .rd_data (ram_rd_data)
    );

endmodule

// File: tb/tb_axi4_full_slave_mem.sv
// tb/tb_axi4_full_slave_mem.sv - directed self-checking bench for axi4_full_slave_mem
module tb_axi4_full_slave_mem;

    localparam int LIM = 64;
`ifdef AXI_SLV_RD_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  S_AXI_AWID;
    logic [63:0]  S_AXI_AWADDR;
    logic [7:0]   S_AXI_AWLEN;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [127:0] S_AXI_WDATA;
    logic [15:0]  S_AXI_WSTRB;
    logic         S_AXI_WLAST;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [11:0]  S_AXI_BID;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [11:0]  S_AXI_ARID;
    logic [63:0]  S_AXI_ARADDR;
    logic [7:0]   S_AXI_ARLEN;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [11:0]  S_AXI_RID;
    logic [127:0] S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RLAST;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;

    always #5 clk = ~clk;

    axi4_full_slave_mem dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_AWID    (S_AXI_AWID),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWLEN   (S_AXI_AWLEN),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WLAST   (S_AXI_WLAST),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BID     (S_AXI_BID),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARID    (S_AXI_ARID),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARLEN   (S_AXI_ARLEN),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RID     (S_AXI_RID),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RLAST   (S_AXI_RLAST),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] wbeat [16];
    logic [1:0]   b_resp;
    logic [11:0]  b_id;

    task automatic axi_write(input logic [63:0] addr, input logic [7:0] len, input logic [11:0] id,
                             input logic [15:0] strb, input int last_at);
        int t;
        S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWVALID = 1'b1;
        t = 0;
        while (!S_AXI_AWREADY && t < LIM) begin tick(); t++; end
        if (!S_AXI_AWREADY) check("aw_timeout", 128'(S_AXI_AWREADY), 128'(1));
        tick();
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            S_AXI_WDATA = wbeat[i]; S_AXI_WSTRB = strb; S_AXI_WLAST = (i == last_at); S_AXI_WVALID = 1'b1;
            t = 0;
            while (!S_AXI_WREADY && t < LIM) begin tick(); t++; end
            if (!S_AXI_WREADY) check("w_timeout", 128'(S_AXI_WREADY), 128'(1));
            tick();
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0; S_AXI_BREADY = 1'b1;
        t = 0;
        while (!S_AXI_BVALID && t < LIM) begin tick(); t++; end
        if (!S_AXI_BVALID) check("b_timeout", 128'(S_AXI_BVALID), 128'(1));
        b_resp = S_AXI_BRESP; b_id = S_AXI_BID;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    logic [127:0] r_data [16];
    logic [1:0]   r_resp [16];
    logic         r_last [16];
    logic [11:0]  r_idv  [16];
    int           r_gap  [16];
    logic         r_stable;

    task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input logic [11:0] id,
                            input int stall_at, input int stall_n);
        int t;
        S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARVALID = 1'b1;
        t = 0;
        while (!S_AXI_ARREADY && t < LIM) begin tick(); t++; end
        if (!S_AXI_ARREADY) check("ar_timeout", 128'(S_AXI_ARREADY), 128'(1));
        tick();
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1; r_stable = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!S_AXI_RVALID && t < LIM) begin tick(); t++; end
            if (!S_AXI_RVALID) check("r_timeout", 128'(S_AXI_RVALID), 128'(1));
            r_gap[i] = t; r_data[i] = S_AXI_RDATA; r_resp[i] = S_AXI_RRESP;
            r_last[i] = S_AXI_RLAST; r_idv[i] = S_AXI_RID;
            if (i == stall_at) begin
                S_AXI_RREADY = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    tick();
                    if (!S_AXI_RVALID || S_AXI_RDATA !== r_data[i] || S_AXI_RLAST !== r_last[i] ||
                        S_AXI_RID !== r_idv[i]) r_stable = 1'b0;
                end
                S_AXI_RREADY = 1'b1;
            end
            tick();
        end
        S_AXI_RREADY = 1'b0;
    endtask

    localparam logic [127:0] D1 = 128'h00112233445566778899AABBCCDDEEFF;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_awready", 128'(S_AXI_AWREADY), 128'(1));
        check("rst_arready", 128'(S_AXI_ARREADY), 128'(1));
        check("rst_wready",  128'(S_AXI_WREADY),  128'(0));
        check("rst_bvalid",  128'(S_AXI_BVALID),  128'(0));
        check("rst_rvalid",  128'(S_AXI_RVALID),  128'(0));
        check("rst_rlast",   128'(S_AXI_RLAST),   128'(0));
        check("rst_bresp",   128'(S_AXI_BRESP),   128'(0));
        check("rst_rresp",   128'(S_AXI_RRESP),   128'(0));
        check("rst_bid",     128'(S_AXI_BID),     128'(0));
        check("rst_rid",     128'(S_AXI_RID),     128'(0));
        check("rst_rdata",   S_AXI_RDATA,         128'(0));

        // single beat write/read
        wbeat[0] = D1;
        axi_write(64'h40, 8'd0, 12'h0A1, 16'hFFFF, 0);
        check("t1_bresp", 128'(b_resp), 128'(2'b00));
        check("t1_bid",   128'(b_id),   128'(12'h0A1));
        axi_read(64'h40, 8'd0, 12'h0B1, -1, 0);
        check("t1_rdata", r_data[0], D1);
        check("t1_rlast", 128'(r_last[0]), 128'(1));
        check("t1_rresp", 128'(r_resp[0]), 128'(2'b00));
        check("t1_rid",   128'(r_idv[0]),  128'(12'h0B1));
        check("t1_lat",   128'(r_gap[0]),  128'(RD_LAT - 1));
        check("t1_arready_back", 128'(S_AXI_ARREADY), 128'(1));

        // 4-beat INCR burst
        for (int i = 0; i < 4; i++) wbeat[i] = 128'(i + 1);
        axi_write(64'h100, 8'd3, 12'h0A2, 16'hFFFF, 3);
        check("t2_bresp", 128'(b_resp), 128'(2'b00));
        axi_read(64'h100, 8'd3, 12'h0B2, -1, 0);
        for (int i = 0; i < 4; i++) begin
            check("t2_rdata", r_data[i], 128'(i + 1));
            check("t2_rlast", 128'(r_last[i]), 128'(i == 3));
            check("t2_gap",   128'(r_gap[i]), 128'(RD_LAT - 1));
        end

        // partial strobe
        wbeat[0] = '0;
        axi_write(64'h200, 8'd0, 12'h0A3, 16'hFFFF, 0);
        wbeat[0] = {128{1'b1}};
        axi_write(64'h200, 8'd0, 12'h0A3, 16'h000F, 0);
        axi_read(64'h200, 8'd0, 12'h0B3, -1, 0);
        check("t3_rdata", r_data[0], 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);

        // out-of-range beats (word 1024 would alias word 0 if not dropped)
        wbeat[0] = 128'h1234;
        axi_write(64'h0, 8'd0, 12'h0A4, 16'hFFFF, 0);
        wbeat[0] = 128'hE0E0; wbeat[1] = 128'hDEAD;
        axi_write(64'h3FF0, 8'd1, 12'h0A4, 16'hFFFF, 1);
        check("t4_bresp_oor", 128'(b_resp), 128'(2'b10));
        axi_read(64'h0, 8'd0, 12'h0B4, -1, 0);
        check("t4_word0_kept", r_data[0], 128'h1234);
        axi_read(64'h3FF0, 8'd1, 12'h0B4, -1, 0);
        check("t4_last_word",  r_data[0], 128'hE0E0);
        check("t4_last_rresp", 128'(r_resp[0]), 128'(2'b00));
        check("t4_oor_rdata",  r_data[1], 128'(0));
        check("t4_oor_rresp",  128'(r_resp[1]), 128'(2'b10));
        axi_read(64'h4000, 8'd0, 12'h0B4, -1, 0);
        check("t4_rd4000_data", r_data[0], 128'(0));
        check("t4_rd4000_resp", 128'(r_resp[0]), 128'(2'b10));

        // RREADY stall mid-burst
        for (int i = 0; i < 4; i++) wbeat[i] = 128'hA0 + 128'(i);
        axi_write(64'h300, 8'd3, 12'h0A5, 16'hFFFF, 3);
        axi_read(64'h300, 8'd3, 12'h0B5, 1, 5);
        check("t5_stable", 128'(r_stable), 128'(1));
        for (int i = 0; i < 4; i++) begin
            check("t5_rdata", r_data[i], 128'hA0 + 128'(i));
            check("t5_rlast", 128'(r_last[i]), 128'(i == 3));
        end

        // early WLAST, then an ordinary write must be OKAY again
        axi_write(64'h380, 8'd3, 12'h0A6, 16'hFFFF, 1);
        check("t5_bresp_wlast", 128'(b_resp), 128'(2'b10));
        wbeat[0] = D1;
        axi_write(64'h40, 8'd0, 12'h0A7, 16'hFFFF, 0);
        check("t5_bresp_clear", 128'(b_resp), 128'(2'b00));

        // reset during beat 2 of an 8-beat read
        S_AXI_ARID = 12'h0B6; S_AXI_ARADDR = 64'h100; S_AXI_ARLEN = 8'd7; S_AXI_ARVALID = 1'b1;
        check("t6_arready", 128'(S_AXI_ARREADY), 128'(1));
        tick();
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
        t = 0;
        while (!S_AXI_RVALID && t < LIM) begin tick(); t++; end
        check("t6_beat0", S_AXI_RDATA, 128'(1));
        tick();
        S_AXI_RREADY = 1'b0;
        t = 0;
        while (!S_AXI_RVALID && t < LIM) begin tick(); t++; end
        check("t6_beat1", S_AXI_RDATA, 128'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rvalid_rst",  128'(S_AXI_RVALID),  128'(0));
        check("t6_arready_rst", 128'(S_AXI_ARREADY), 128'(1));
        axi_read(64'h40, 8'd0, 12'h0B7, -1, 0);
        check("t6_rdata", r_data[0], D1);
        check("t6_rresp", 128'(r_resp[0]), 128'(2'b00));
        check("t6_rlast", 128'(r_last[0]), 128'(1));
        check("t6_rid",   128'(r_idv[0]),  128'(12'h0B7));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
